// File: rtl/ledpwm_pkg.sv
// ============================================================================
//  Module      : ledpwm_pkg
//  Description : Shared defaults, per-LED setting type and gamma mapping for
//                the LED PWM driver (gamma used when LEDPWM_GAMMA_EN is set).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ledpwm_pkg;

    localparam int c_nled_default    = 8;
    localparam int c_lgpwm_default   = 8;
    localparam int c_lgblink_default = 24;

    // Level field is sized for the widest supported LGPWM; narrower builds
    // zero-extend into it.
    localparam int c_level_w = 16;

    typedef struct packed {
        logic [c_level_w-1:0] level;
        logic                 blink;
    } led_setting_t;

    function automatic logic [c_level_w-1:0] gamma_eff(
        input logic [c_level_w-1:0] level,
        input int                   lgpwm
    );
        logic [c_level_w-1:0] full;
        logic [c_level_w-1:0] eff;
        full = c_level_w'((32'd1 << lgpwm) - 32'd1);
        eff  = c_level_w'(((2*c_level_w)'(level) * (2*c_level_w)'(level)) >> lgpwm);
        if (level == full) begin
            eff = full;
        end else if ((level != '0) && (eff == '0)) begin
            eff = c_level_w'(1);
        end
        return eff;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ledpwm_channel.sv
// ============================================================================
//  Module      : ledpwm_channel
//  Description : One LED: pending/active settings, effective level, PWM
//                compare and blink gating. LEDPWM_GAMMA_EN selects gamma.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ledpwm_channel
    import ledpwm_pkg::*;
#(
    parameter int LGPWM = c_lgpwm_default
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_wr,
    input  led_setting_t     i_setting,
    input  logic [LGPWM-1:0] i_pwm_cnt,
    input  logic             i_boundary,
    input  logic             i_blink_phase,
    output logic             o_led
);

    localparam logic [c_level_w-1:0] c_full = c_level_w'((32'd1 << LGPWM) - 32'd1);

    led_setting_t         r_pending;
    led_setting_t         r_active;
    logic                 r_led;
    logic [c_level_w-1:0] w_eff;
    logic                 w_duty;
    logic                 w_drive;

`ifdef LEDPWM_GAMMA_EN
    assign w_eff = gamma_eff(r_active.level, LGPWM);
`else
    assign w_eff = r_active.level;
`endif

    always_comb begin
        w_duty = 1'b0;
        if (w_eff == '0) begin
            w_duty = 1'b0;
        end else if (w_eff == c_full) begin
            w_duty = 1'b1;
        end else begin
            w_duty = (c_level_w'(i_pwm_cnt) < w_eff);
        end
    end

    assign w_drive = w_duty & (~r_active.blink | i_blink_phase);

    // Boundary load sees the pre-write pending value when both land together.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pending <= '0;
            r_active  <= '0;
            r_led     <= 1'b0;
        end else begin
            if (i_wr) begin
                r_pending <= i_setting;
            end
            if (i_boundary) begin
                r_active <= r_pending;
            end
            r_led <= w_drive;
        end
    end

    assign o_led = r_led;

endmodule

`default_nettype wire

// File: rtl/ledpwm_driver.sv
// ============================================================================
//  Module      : ledpwm_driver
//  Description : LED bank driver: shared PWM/blink counters, write decode and
//                per-LED channels. Define LEDPWM_GAMMA_EN for gamma brightness.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ledpwm_driver
    import ledpwm_pkg::*;
#(
    parameter int NLED    = c_nled_default,
    parameter int LGPWM   = c_lgpwm_default,
    parameter int LGBLINK = c_lgblink_default
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_wr,
    input  logic [$clog2(NLED)-1:0] i_led,
    input  logic [LGPWM-1:0]        i_level,
    input  logic                    i_blink,
    output logic                    o_ack,
    output logic [NLED-1:0]         o_leds
);

    logic [LGPWM-1:0]   r_pwm_cnt;
    logic [LGBLINK-1:0] r_blink_cnt;
    logic               r_ack;
    logic               w_boundary;
    led_setting_t       w_setting;

    assign w_boundary = &r_pwm_cnt;
    assign w_setting  = '{level: c_level_w'(i_level), blink: i_blink};

    // Out-of-range indices match no channel but are still acknowledged.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_pwm_cnt   <= '0;
            r_blink_cnt <= '0;
            r_ack       <= 1'b0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            r_ack       <= i_wr;
        end
    end

    assign o_ack = r_ack;

    for (genvar g = 0; g < NLED; g++) begin : g_chan
        logic w_sel;
        assign w_sel = i_wr && (32'(i_led) == 32'(g));

        ledpwm_channel #(
            .LGPWM (LGPWM)
        ) u_channel (
            .i_clk         (i_clk),
            .i_reset_n     (i_reset_n),
            .i_wr          (w_sel),
            .i_setting     (w_setting),
            .i_pwm_cnt     (r_pwm_cnt),
            .i_boundary    (w_boundary),
            .i_blink_phase (r_blink_cnt[LGBLINK-1]),
            .o_led         (o_leds[g])
        );
    end

endmodule

`default_nettype wire
